circular_convolution: RTL and testbench
=======================================

Name: circular_convolution

Overview:
- Sequential signed convolution engine. Takes vector A (size_n samples) and vector B (size_m samples) and produces the size_n+size_m-1 output samples of their linear convolution.
- Used as a compute block inside a DSP datapath. Inputs and outputs are presented as unpacked arrays.
- Computes one output sample per clock, then holds the result vector until the next start.

Parameters:
- size_n, 4, number of samples in A (≥1)
- size_m, 4, number of samples in B (≥1)
- width, 8, bit width of each signed input sample; output samples are 2*width bits

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  level request to begin a computation
- A  input  signed [width-1:0] x size_n  input vector; A[0] is the first sample
- B  input  signed [width-1:0] x size_m  input vector; B[0] is the first sample
- C  output  signed [2*width-1:0] x (size_n+size_m-1)  result vector
- done  output  1  high while C holds a valid, complete result

Behaviour:
- Reset (reset=0, asynchronous):
  - All C entries = 0, done=0, state=IDLE, index counter k=0.
  - Internal copies of A and B are cleared.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - On a clk edge with start=1: latch A and B into internal registers, set k=0, clear done, go to COMPUTE.
  - C keeps its previous contents until overwritten.
- COMPUTE:
  - Each cycle, C[k] <= sum over all i+j=k (0≤i<size_n, 0≤j<size_m) of Aq[i]*Bq[j], using the latched copies Aq and Bq.
  - k increments each cycle.
  - After k = size_n+size_m-2 is written, go to DONE and set done=1.
  - Inputs A and B are ignored while in COMPUTE.
- DONE:
  - C and done hold.
  - When start=0, go to IDLE. done stays high in IDLE until the next start is accepted.
  - A start held continuously high does not retrigger a computation; start must go low and then high again.
- Latency: the start-accepting edge plus size_n+size_m-1 COMPUTE edges. With defaults, done rises on the 8th rising edge after start is sampled, which is within 10 cycles.
- Arithmetic:
  - Products are signed width x width, giving 2*width bits.
  - The accumulation is carried in 2*width bits and wraps (two's complement, modulo 2^(2*width)). No saturation, no overflow flag.
- A reset during COMPUTE aborts the computation immediately: C=0, done=0, state=IDLE.
- size_n=1 or size_m=1 is legal and degenerates to scaling.

Optional Feature:
- Macro: CIRC_FOLD_EN.
- When defined:
  - After the linear pass, one extra FOLD cycle is inserted before DONE.
  - In the FOLD cycle, for L=max(size_n,size_m): C[k] <= C[k] + C[k+L] for each k < size_n+size_m-1-L, and C[k+L] <= 0.
  - C[0..L-1] then holds the L-point circular convolution, with 2*width wrap arithmetic.
  - Latency grows by 1 cycle.
- When undefined: output is the linear convolution only, with the latency given above.

Decomposition:
- Package circular_convolution_pkg:
  - state enum (IDLE, COMPUTE, FOLD, DONE);
  - localparam function computing output length (size_n+size_m-1);
  - helper for the counter width, $clog2 of the output length.
- Sub-module conv_mac_lane:
  - Combinational.
  - Given Aq, Bq and index k, returns the 2*width sum of products with i+j=k, masking out-of-range terms.
  - Parameterised like the top.

Test Plan:
- A={1,1,1,1}, B={1,1,1,1}, reset pulse, then start=1 held → within 10 cycles done=1 and C = 1,2,3,4,3,2,1. No retrigger while start stays high.
- A={1,-2,3,-4}, B={1,0,0,0} → C = 1,-2,3,-4,0,0,0.
- A={-128,-128,-128,-128}, B={-128,-128,-128,-128}, width=8 → C[0]=16384, C[1]=-32768 (wrapped), C[2]=-16384, C[3]=0 (wrapped), C[4]=-16384, C[5]=-32768, C[6]=16384.
- Start with A/B = all ones, assert reset low on the 3rd COMPUTE cycle → C all 0, done=0. Release reset, pulse start with A={2,0,0,0}, B={1,2,3,4} → C = 2,4,6,8,0,0,0.
- Run once, drop start, change A to {0,0,0,1}, raise start → C = 0,0,0,1,2,3,4 with B={1,2,3,4}. C unchanged and done=1 between runs until start is accepted.
- With CIRC_FOLD_EN, all-ones inputs → C = 4,4,4,4,0,0,0 one cycle later than the non-fold latency.

Source files
------------

// File: rtl/circular_convolution_pkg.sv
// Shared types and sizing helpers for the convolution engine.
// Optional circular fold stage is enabled with CIRC_FOLD_EN.
package circular_convolution_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        FOLD,
        DONE
    } state_t;

    function automatic int out_len(input int n, input int m);
        return n + m - 1;
    endfunction

    function automatic int cnt_w(input int n, input int m);
        return (out_len(n, m) > 1) ? $clog2(out_len(n, m)) : 1;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// Combinational sum of products A[i]*B[j] over all i+j == k.
// Accumulation wraps modulo 2^(2*width).
module conv_mac_lane
    import circular_convolution_pkg::*;
#(
    parameter int size_n = 4,
    parameter int size_m = 4,
    parameter int width  = 8,
    parameter int kw     = cnt_w(size_n, size_m)
) (
    input  logic signed [width-1:0]   a [size_n],
    input  logic signed [width-1:0]   b [size_m],
    input  logic        [kw-1:0]      k,
    output logic signed [2*width-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < size_n; i++) begin
            for (int j = 0; j < size_m; j++) begin
                if (i + j == int'(k)) begin
                    sum = sum + (2*width)'(a[i]) * (2*width)'(b[j]);
                end
            end
        end
    end

endmodule

// File: rtl/circular_convolution.sv
// Sequential convolution engine: one output sample per clock.
// Define CIRC_FOLD_EN to add a fold cycle yielding circular convolution.
module circular_convolution
    import circular_convolution_pkg::*;
#(
    parameter int size_n = 4,
    parameter int size_m = 4,
    parameter int width  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [width-1:0]   A [size_n],
    input  logic signed [width-1:0]   B [size_m],
    output logic signed [2*width-1:0] C [size_n+size_m-1],
    output logic                      done
);

    localparam int olen = out_len(size_n, size_m);
    localparam int kw   = cnt_w(size_n, size_m);
    localparam int fl   = (size_n > size_m) ? size_n : size_m;

    state_t                   state;
    logic [kw-1:0]            k;
    logic signed [width-1:0]  aq [size_n];
    logic signed [width-1:0]  bq [size_m];
    logic signed [2*width-1:0] sum;

    conv_mac_lane #(
        .size_n (size_n),
        .size_m (size_m),
        .width  (width),
        .kw     (kw)
    ) u_lane (
        .a   (aq),
        .b   (bq),
        .k   (k),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            k     <= '0;
            done  <= 1'b0;
            for (int i = 0; i < olen; i++) C[i] <= '0;
            for (int i = 0; i < size_n; i++) aq[i] <= '0;
            for (int i = 0; i < size_m; i++) bq[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        aq    <= A;
                        bq    <= B;
                        k     <= '0;
                        done  <= 1'b0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    C[k] <= sum;
                    if (k == kw'(olen - 1)) begin
                        k <= '0;
`ifdef CIRC_FOLD_EN
                        state <= FOLD;
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        k <= k + kw'(1);
                    end
                end
`ifdef CIRC_FOLD_EN
                FOLD: begin
                    // wrap the tail onto the head of the first L samples
                    for (int i = 0; i < olen - fl; i++) begin
                        C[i]      <= C[i] + C[i+fl];
                        C[i+fl]   <= '0;
                    end
                    state <= DONE;
                    done  <= 1'b1;
                end
`endif
                DONE: begin
                    if (!start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_circular_convolution.sv
// Table-driven bench with an expected-result queue for circular_convolution.
module tb_circular_convolution;

    localparam int N = 4;
    localparam int M = 4;
    localparam int W = 8;
    localparam int O = 7;
`ifdef CIRC_FOLD_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    typedef logic [3:0][7:0]  v4_t;
    typedef logic [6:0][15:0] v7_t;
    typedef struct packed {
        v4_t a;
        v4_t b;
        v7_t c;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic signed [W-1:0]   A [N];
    logic signed [W-1:0]   B [M];
    logic signed [2*W-1:0] C [O];
    logic done;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl [5];
    v7_t exp_q [$];

    always #5 clk = ~clk;

    circular_convolution #(
        .size_n (N),
        .size_m (M),
        .width  (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .done  (done)
    );

    function automatic v4_t p4(input int x0, input int x1,
                               input int x2, input int x3);
        v4_t r;
        r[0] = x0[7:0];
        r[1] = x1[7:0];
        r[2] = x2[7:0];
        r[3] = x3[7:0];
        return r;
    endfunction

    function automatic v7_t p7(input int x0, input int x1, input int x2,
                               input int x3, input int x4, input int x5,
                               input int x6);
        v7_t r;
        r[0] = x0[15:0];
        r[1] = x1[15:0];
        r[2] = x2[15:0];
        r[3] = x3[15:0];
        r[4] = x4[15:0];
        r[5] = x5[15:0];
        r[6] = x6[15:0];
        return r;
    endfunction

    function automatic v7_t fold(input v7_t c);
        v7_t r;
        r = c;
`ifdef CIRC_FOLD_EN
        for (int i = 0; i < 3; i++) begin
            r[i]   = c[i] + c[i+4];
            r[i+4] = '0;
        end
`endif
        return r;
    endfunction

    function automatic v7_t cflat();
        v7_t r;
        for (int i = 0; i < O; i++) r[i] = C[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [111:0] got,
                       input logic [111:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic apply(input v4_t a, input v4_t b);
        for (int i = 0; i < 4; i++) begin
            A[i] = a[i];
            B[i] = b[i];
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < 4; i++) begin
            A[i] = 8'($urandom);
            B[i] = 8'($urandom);
        end
    endtask

    task automatic run(input vec_t v);
        int  cycles;
        v7_t e;
        apply(v.a, v.b);
        start = 1'b1;
        exp_q.push_back(fold(v.c));
        @(posedge clk); #1;
        chk("accept_done_low", 112'(done), 112'(0));
        scramble();
        cycles = 1;
        while (!done && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("latency", 112'(cycles), 112'(LAT));
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL queue got=empty want=entry");
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("result", cflat(), e);
        repeat (3) @(posedge clk);
        #1;
        chk("no_retrigger", {cflat(), done}, {e, 1'b1});
        start = 1'b0;
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #1;
        chk("idle_hold", {cflat(), done}, {e, 1'b1});
    endtask

    initial begin
        tbl[0] = '{a: p4(1, 1, 1, 1), b: p4(1, 1, 1, 1),
                   c: p7(1, 2, 3, 4, 3, 2, 1)};
        tbl[1] = '{a: p4(1, -2, 3, -4), b: p4(1, 0, 0, 0),
                   c: p7(1, -2, 3, -4, 0, 0, 0)};
        tbl[2] = '{a: p4(-128, -128, -128, -128),
                   b: p4(-128, -128, -128, -128),
                   c: p7(16384, -32768, -16384, 0,
                         -16384, -32768, 16384)};
        tbl[3] = '{a: p4(0, 0, 0, 1), b: p4(1, 2, 3, 4),
                   c: p7(0, 0, 0, 1, 2, 3, 4)};
        tbl[4] = '{a: p4(2, 0, 0, 0), b: p4(1, 2, 3, 4),
                   c: p7(2, 4, 6, 8, 0, 0, 0)};

        apply(p4(1, 1, 1, 1), p4(1, 1, 1, 1));
        #12;
        chk("reset_C", cflat(), '0);
        chk("reset_done", 112'(done), 112'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) run(tbl[t]);

        apply(p4(1, 1, 1, 1), p4(1, 1, 1, 1));
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("abort_C", cflat(), '0);
        chk("abort_done", 112'(done), 112'(0));
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_done", 112'(done), 112'(0));
        run(tbl[4]);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
